// File: rtl/uart_rx_if.sv
// Receive-side signal bundle: serial line in, framed word and status strobes out.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    output rx,
    input  rx_data, rx_valid, frame_err, parity_err, busy
  );

  modport slave (
    input  rx,
    output rx_data, rx_valid, frame_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: two-flop line synchroniser, mid-bit sampling, optional parity,
// stop-bit check, one-cycle registered result strobes.
//   state     | meaning
//   IDLE      | line idle, waiting for a falling edge
//   START     | confirming the start bit at its midpoint
//   DATA      | sampling data bits, LSB first
//   PARITY    | sampling the parity bit
//   STOP      | sampling the stop bit
//   WAIT_IDLE | stop bit was low (break), waiting for the line to return high
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave rx_bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_out_q, perr_out_d;
  logic                 rxs;
  logic                 tick;

  assign rxs  = sync_q[1];
  assign tick = (state_q == START) ? (cnt_q == HALF_TC) : (cnt_q == FULL_TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_out_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx_bus.rx};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_out_q <= perr_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    perr_d     = perr_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    perr_out_d = 1'b0;
    // Every tick or state change restarts the bit timer.
    if (tick || state_q == IDLE || state_q == WAIT_IDLE) cnt_d = '0;
    case (state_q)
      IDLE: if (!rxs) state_d = START;
      START: if (tick) state_d = rxs ? IDLE : DATA;
      DATA: begin
        if (tick) begin
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          perr_d  = (^shift_q) ^ rxs ^ 1'(PARITY_ODD);
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (rxs) begin
            data_d     = shift_q;
            valid_d    = 1'b1;
            perr_out_d = perr_q & (PARITY_EN != 0);
            state_d    = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rx_bus.rx_data    = data_q;
  assign rx_bus.rx_valid   = valid_q;
  assign rx_bus.frame_err  = ferr_q;
  assign rx_bus.parity_err = perr_out_q;
  assign rx_bus.busy       = (state_q != IDLE);

endmodule
